// File: rtl/freq_pkg.sv
// freq_pkg: shared definitions for the frequency meter measurement sequencer.
//   state_t    - sequencer state encoding (3 bits)
//   RANGE_*    - gate range codes, also the decimal-point position
//   decade()   - 10^r for r = 0..3, used to scale the gate length
package freq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EVAL  = 3'd4,
    ST_LATCH = 3'd5
  } state_t;

  localparam logic [1:0] RANGE_10MS  = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_1S    = 2'd2;
  localparam logic [1:0] RANGE_10S   = 2'd3;

  function automatic logic [31:0] decade(input logic [1:0] r);
    logic [31:0] d;
    case (r)
      RANGE_10MS:  d = 32'd1;
      RANGE_100MS: d = 32'd10;
      RANGE_1S:    d = 32'd100;
      RANGE_10S:   d = 32'd1000;
      default:     d = 32'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/freq_gate_timer.sv
// freq_gate_timer: loadable down counter that times the counting gate.
//   fpga_clk, nreset - clock, asynchronous active-low reset
//   load, load_val   - load the gate length (takes priority)
//   clr              - force the counter to 0 while no gate is pending
//   tick_en          - decrement by one (1 us tick gated by the sequencer)
//   expire           - pulse on the tick that brings the counter to 0
module freq_gate_timer #(
  parameter int GATE_W = 24
) (
  input  logic              fpga_clk,
  input  logic              nreset,
  input  logic              load,
  input  logic [GATE_W-1:0] load_val,
  input  logic              clr,
  input  logic              tick_en,
  output logic              expire
);

  localparam logic [GATE_W-1:0] CNT_ZERO = {GATE_W{1'b0}};
  localparam logic [GATE_W-1:0] CNT_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};

  logic [GATE_W-1:0] count_r;

  // Gate length counter; saturates at 0 so it never wraps.
  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (tick_en && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // Combinational so the sequencer leaves GATE on the final tick itself.
  assign expire = tick_en && (count_r == CNT_ONE);

endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: measurement sequencer and auto-ranger for the frequency meter.
//   fpga_clk, nreset     - clock, asynchronous active-low reset
//   tick_1us             - 1 us timebase pulse
//   sig_edge             - one pulse per synchronized input edge
//   carry_out, msd_zero  - BCD counter overflow and "digit 7 is 0"
//   run, auto_en, man_range - operating controls
//   clk_enable, reset_ctr, latchit - BCD counter control pins
//   range, ovf           - range / overflow of the last latched value
//   gate_active, meas_done - gate open, measurement latched
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int GATE_BASE_US = 10_000,
  parameter int GATE_W       = 24,
  parameter int INIT_RANGE   = 2
) (
  input  logic       fpga_clk,
  input  logic       nreset,
  input  logic       tick_1us,
  input  logic       sig_edge,
  input  logic       carry_out,
  input  logic       msd_zero,
  input  logic       run,
  input  logic       auto_en,
  input  logic [1:0] man_range,
  output logic       clk_enable,
  output logic       reset_ctr,
  output logic       latchit,
  output logic [1:0] range,
  output logic       ovf,
  output logic       gate_active,
  output logic       meas_done
);

  localparam logic [1:0] INIT_RNG = 2'(INIT_RANGE);
  localparam logic [GATE_W-1:0] LEN0 = GATE_W'(GATE_BASE_US * decade(RANGE_10MS));
  localparam logic [GATE_W-1:0] LEN1 = GATE_W'(GATE_BASE_US * decade(RANGE_100MS));
  localparam logic [GATE_W-1:0] LEN2 = GATE_W'(GATE_BASE_US * decade(RANGE_1S));
  localparam logic [GATE_W-1:0] LEN3 = GATE_W'(GATE_BASE_US * decade(RANGE_10S));

  state_t            state_r, state_nxt_s;
  logic [1:0]        cur_rng_r, cur_rng_nxt_s;
  logic              ovf_seen_r, ovf_seen_nxt_s;
  logic [GATE_W-1:0] gate_len_s;
  logic              expire_s;

  logic clk_enable_r, reset_ctr_r, latchit_r, meas_done_r, gate_active_r, ovf_r;
  logic [1:0] range_r;

  // Gate length for the working range.
  always_comb begin
    gate_len_s = LEN0;
    case (cur_rng_r)
      RANGE_10MS:  gate_len_s = LEN0;
      RANGE_100MS: gate_len_s = LEN1;
      RANGE_1S:    gate_len_s = LEN2;
      RANGE_10S:   gate_len_s = LEN3;
      default:     gate_len_s = LEN0;
    endcase
  end

  freq_gate_timer #(.GATE_W(GATE_W)) u_timer (
    .fpga_clk (fpga_clk),
    .nreset   (nreset),
    .load     (state_r == ST_CLEAR),
    .load_val (gate_len_s),
    .clr      ((state_r != ST_CLEAR) && (state_r != ST_GATE)),
    .tick_en  (tick_1us && (state_r == ST_GATE)),
    .expire   (expire_s)
  );

  // Sequencer state, working range and sticky overflow registers.
  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      state_r    <= ST_IDLE;
      cur_rng_r  <= INIT_RNG;
      ovf_seen_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cur_rng_r  <= cur_rng_nxt_s;
      ovf_seen_r <= ovf_seen_nxt_s;
    end
  end

  // Next-state, range stepping and overflow tracking.
  always_comb begin
    state_nxt_s    = state_r;
    cur_rng_nxt_s  = cur_rng_r;
    ovf_seen_nxt_s = ovf_seen_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_nxt_s = ST_CLEAR;
          if (!auto_en) begin
            cur_rng_nxt_s = man_range;
          end else begin
            cur_rng_nxt_s = cur_rng_r;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        ovf_seen_nxt_s = 1'b0;
        if (run) begin
          state_nxt_s = ST_GATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (carry_out) begin
          ovf_seen_nxt_s = 1'b1;
        end else begin
          ovf_seen_nxt_s = ovf_seen_r;
        end
        if (!run) begin
          state_nxt_s = ST_IDLE;
        end else if (expire_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_GATE;
        end
      end
      ST_DRAIN: begin
        if (run) begin
          state_nxt_s = ST_EVAL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EVAL: begin
        // Overflowed in auto mode: step down a range and re-measure unlatched.
        if (!run) begin
          state_nxt_s = ST_IDLE;
        end else if (auto_en && ovf_seen_r && (cur_rng_r != RANGE_10MS)) begin
          cur_rng_nxt_s = cur_rng_r - 2'd1;
          state_nxt_s   = ST_CLEAR;
        end else begin
          state_nxt_s = ST_LATCH;
        end
      end
      ST_LATCH: begin
        // Leading digit empty: a 10x longer gate still fits 8 digits.
        if (auto_en) begin
          if (msd_zero && !ovf_seen_r && (cur_rng_r != RANGE_10S)) begin
            cur_rng_nxt_s = cur_rng_r + 2'd1;
          end else begin
            cur_rng_nxt_s = cur_rng_r;
          end
        end else begin
          cur_rng_nxt_s = man_range;
        end
        if (run) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, decoded from the state being entered so they line
  // up with the state register; range/ovf change together with latchit.
  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      clk_enable_r  <= 1'b0;
      reset_ctr_r   <= 1'b0;
      latchit_r     <= 1'b0;
      meas_done_r   <= 1'b0;
      gate_active_r <= 1'b0;
      ovf_r         <= 1'b0;
      range_r       <= INIT_RNG;
    end else begin
      clk_enable_r  <= (state_r == ST_GATE) && run && sig_edge;
      reset_ctr_r   <= (state_nxt_s == ST_CLEAR);
      latchit_r     <= (state_nxt_s == ST_LATCH);
      meas_done_r   <= (state_nxt_s == ST_LATCH);
      gate_active_r <= (state_nxt_s == ST_GATE);
      if (state_nxt_s == ST_LATCH) begin
        range_r <= cur_rng_r;
        ovf_r   <= ovf_seen_r;
      end else begin
        range_r <= range_r;
        ovf_r   <= ovf_r;
      end
    end
  end

  assign clk_enable  = clk_enable_r;
  assign reset_ctr   = reset_ctr_r;
  assign latchit     = latchit_r;
  assign meas_done   = meas_done_r;
  assign gate_active = gate_active_r;
  assign range       = range_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: directed scoreboard bench for freq_gate_ctrl (GATE_BASE_US=10).
// Stimulus pushes the expected latch result {range, ovf, edges counted,
// gate ticks, cycles reset_ctr->latchit}; a monitor pops it on meas_done.
module tb_freq_gate_ctrl;

  logic       fpga_clk  = 1'b0;
  logic       nreset    = 1'b0;
  logic       tick_1us  = 1'b0;
  logic       sig_edge  = 1'b0;
  logic       carry_out = 1'b0;
  logic       msd_zero  = 1'b0;
  logic       run       = 1'b0;
  logic       auto_en   = 1'b0;
  logic [1:0] man_range = 2'd0;
  logic       clk_enable, reset_ctr, latchit, ovf, gate_active, meas_done;
  logic [1:0] range;

  freq_gate_ctrl #(.GATE_BASE_US(10), .GATE_W(24), .INIT_RANGE(2)) dut (
    .fpga_clk    (fpga_clk),
    .nreset      (nreset),
    .tick_1us    (tick_1us),
    .sig_edge    (sig_edge),
    .carry_out   (carry_out),
    .msd_zero    (msd_zero),
    .run         (run),
    .auto_en     (auto_en),
    .man_range   (man_range),
    .clk_enable  (clk_enable),
    .reset_ctr   (reset_ctr),
    .latchit     (latchit),
    .range       (range),
    .ovf         (ovf),
    .gate_active (gate_active),
    .meas_done   (meas_done)
  );

  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    logic [1:0] rng;
    logic       ovf;
    int         edges;
    int         ticks;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int n_latched = 0;

  // stimulus generator settings
  int tick_per = 5;
  int edge_per = 0;
  int edge_ofs = 0;
  bit carry_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] r, input logic o, input int e, input int t, input int l);
    exp_t x;
    x.rng = r; x.ovf = o; x.edges = e; x.ticks = t; x.lat = l;
    sb_q.push_back(x);
  endtask

  task automatic wait_latch(input int target, input int budget);
    int cnt = 0;
    while (n_latched < target && cnt < budget) begin
      @(negedge fpga_clk);
      cnt++;
    end
    total++;
    if (n_latched < target) begin
      bad++;
      $display("FAIL latch_timeout: got %0d latches, required %0d", n_latched, target);
    end
  endtask

  task automatic stop_run();
    @(posedge fpga_clk); #2;
    run = 1'b0;
    repeat (5) @(posedge fpga_clk);
    #2;
  endtask

  // Tick/edge/carry generator, phase restarted at each gate opening.
  initial begin
    int gc = 0;
    logic g_prev = 1'b0;
    forever begin
      @(posedge fpga_clk); #2;
      if (gate_active && !g_prev) gc = 0;
      else gc = gc + 1;
      g_prev    = gate_active;
      tick_1us  = ((gc % tick_per) == tick_per - 1);
      sig_edge  = (edge_per != 0) && ((gc % edge_per) == edge_ofs);
      carry_out = carry_on && gate_active && (gc == 3);
    end
  end

  // Monitor: measures each measurement and checks it against the scoreboard.
  initial begin
    int m_edges = 0, m_ticks = 0, m_lat = 0;
    bit pend = 1'b0;
    exp_t cur;
    forever begin
      @(negedge fpga_clk);
      if (!nreset) begin
        m_edges = 0; m_ticks = 0; m_lat = 0; pend = 1'b0;
      end else begin
        if (pend) begin
          pend = 1'b0;
          chk("latched_range", 32'(range), 32'(cur.rng));
          chk("latched_ovf", 32'(ovf), 32'(cur.ovf));
        end
        if (reset_ctr) begin
          m_edges = 0; m_ticks = 0; m_lat = 0;
        end else begin
          m_lat++;
          if (clk_enable) m_edges++;
          if (gate_active && tick_1us) m_ticks++;
        end
        if (meas_done) begin
          n_latched++;
          chk("latchit_with_done", 32'(latchit), 32'd1);
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_latch: got meas_done range=%0d, required no latch", range);
          end else begin
            cur = sb_q.pop_front();
            chk("edges_counted", 32'(m_edges), 32'(cur.edges));
            chk("gate_ticks", 32'(m_ticks), 32'(cur.ticks));
            chk("clear_to_latch", 32'(m_lat), 32'(cur.lat));
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int first;
    // reset state
    repeat (3) @(negedge fpga_clk);
    chk("rst_reset_ctr", 32'(reset_ctr), 32'd0);
    chk("rst_latchit", 32'(latchit), 32'd0);
    chk("rst_clk_enable", 32'(clk_enable), 32'd0);
    chk("rst_gate_active", 32'(gate_active), 32'd0);
    chk("rst_meas_done", 32'(meas_done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_range", 32'(range), 32'd2);
    @(posedge fpga_clk); #2;
    nreset = 1'b1;

    // manual range 0: 10 ticks x 5 clks, edges at gate clks 9/29/49
    tick_per = 5; edge_per = 20; edge_ofs = 9; man_range = 2'd0;
    push_exp(2'd0, 1'b0, 3, 10, 53);
    run = 1'b1;
    wait_latch(n_latched + 1, 300);
    stop_run();

    // manual range 1, edge on every tick (last one coincides with final tick)
    edge_per = 5; edge_ofs = 4; man_range = 2'd1;
    push_exp(2'd1, 1'b0, 100, 100, 503);
    run = 1'b1;
    wait_latch(n_latched + 1, 800);
    stop_run();

    // run dropped mid-gate: abandon, hold range/ovf, no latch
    run = 1'b1;
    repeat (100) @(posedge fpga_clk);
    #2;
    run = 1'b0;
    @(posedge fpga_clk);
    @(negedge fpga_clk);
    chk("abort_gate_active", 32'(gate_active), 32'd0);
    chk("abort_clk_enable", 32'(clk_enable), 32'd0);
    chk("abort_range_hold", 32'(range), 32'd1);
    chk("abort_ovf_hold", 32'(ovf), 32'd0);
    repeat (40) @(posedge fpga_clk);
    #2;
    man_range = 2'd0;
    push_exp(2'd0, 1'b0, 10, 10, 53);
    run = 1'b1;
    first = 0;
    repeat (3) begin
      @(negedge fpga_clk);
      if (reset_ctr) first = 1;
    end
    chk("rerun_reset_ctr", 32'(first), 32'd1);
    wait_latch(n_latched + 1, 300);
    stop_run();

    // auto mode from INIT_RANGE, msd_zero=1: ranges 2,3,3
    nreset = 1'b0;
    @(posedge fpga_clk); #2;
    nreset = 1'b1;
    auto_en = 1'b1; msd_zero = 1'b1; tick_per = 1; edge_per = 0;
    push_exp(2'd2, 1'b0, 0, 1000, 1003);
    push_exp(2'd3, 1'b0, 0, 10000, 10003);
    push_exp(2'd3, 1'b0, 0, 10000, 10003);
    run = 1'b1;
    wait_latch(n_latched + 3, 25000);
    repeat (100) @(negedge fpga_clk);
    chk("pre_reset_range", 32'(range), 32'd3);
    chk("pre_reset_gate", 32'(gate_active), 32'd1);

    // asynchronous reset mid-gate
    @(posedge fpga_clk); #2;
    nreset = 1'b0;
    #1;
    chk("areset_gate_active", 32'(gate_active), 32'd0);
    chk("areset_reset_ctr", 32'(reset_ctr), 32'd0);
    chk("areset_latchit", 32'(latchit), 32'd0);
    chk("areset_range", 32'(range), 32'd2);
    chk("areset_ovf", 32'(ovf), 32'd0);
    chk("areset_queue_empty", 32'(sb_q.size()), 32'd0);

    // auto with carry every gate: ranges 2 and 1 re-measure, range 0 latches ovf
    msd_zero = 1'b0; carry_on = 1'b1;
    push_exp(2'd0, 1'b1, 0, 10, 13);
    @(posedge fpga_clk); #2;
    nreset = 1'b1;
    first = 0;
    repeat (4) begin
      @(negedge fpga_clk);
      if (first == 0) begin
        if (reset_ctr) first = 1;
        else if (gate_active || latchit || clk_enable) first = 2;
      end
    end
    chk("post_reset_first_clear", 32'(first), 32'd1);
    wait_latch(n_latched + 1, 2000);
    stop_run();
    carry_on = 1'b0;

    repeat (10) @(posedge fpga_clk);
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
